// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch PC owner and single-outstanding IMEM fetch sequencer (optional FETCH_PERF_CNT_EN)
module fetch_sequencer #(
    parameter int                AWIDTH       = 32,
    parameter logic [AWIDTH-1:0] RESET_PC_VAL = 32'h4000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redir_ex_valid,
    input  logic [AWIDTH-1:0] redir_ex_target,
    input  logic              redir_id_valid,
    input  logic [AWIDTH-1:0] redir_id_target,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [AWIDTH-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_instr,
    output logic [AWIDTH-1:0] if_pc,
    output logic              flush_out,
    output logic [AWIDTH-1:0] pc_out,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_redir_cnt
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] pc_q, pc_d;
    logic [AWIDTH-1:0] pend_pc_q, pend_pc_d;
    logic              squash_q, squash_d;
    logic              if_valid_q, if_valid_d;
    logic [31:0]       if_instr_q, if_instr_d;
    logic [AWIDTH-1:0] if_pc_q, if_pc_d;

    logic              taken;
    logic [AWIDTH-1:0] redir_pc;
    logic              fetch_fire;

    // EX redirect has priority; targets are always word aligned
    always_comb begin
        taken    = redir_ex_valid | redir_id_valid;
        redir_pc = redir_ex_valid ? redir_ex_target : redir_id_target;
        redir_pc[1:0] = 2'b00;
    end

    // a redirect suppresses the request issued in the same cycle; nothing is requested during reset
    assign imem_req_valid = rst_n & (state_q == ST_REQ) & ~taken;
    assign imem_addr      = pc_q;
    assign pc_out         = pc_q;
    assign flush_out      = rst_n & taken;
    assign if_valid       = if_valid_q;
    assign if_instr       = if_instr_q;
    assign if_pc          = if_pc_q;
    // a held instruction dropped by a redirect is not counted as delivered
    assign fetch_fire     = if_valid_q & if_ready & ~taken;

    // next-state and datapath updates; redirect overrides acceptance and increment
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        squash_d   = squash_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if (taken) begin
            pc_d = redir_pc;
        end
        case (state_q)
            ST_REQ: begin
                if (!taken && imem_req_ready) begin
                    pend_pc_d = pc_q;
                    pc_d      = pc_q + AWIDTH'(4);
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    // a response arriving with a redirect is the wrong-path one: drop it
                    if (squash_q || taken) begin
                        squash_d = 1'b0;
                        state_d  = ST_REQ;
                    end else begin
                        if_valid_d = 1'b1;
                        if_instr_d = imem_rsp_data;
                        if_pc_d    = pend_pc_q;
                        state_d    = ST_HOLD;
                    end
                end else if (taken) begin
                    squash_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (taken || if_ready) begin
                    if_valid_d = 1'b0;
                    state_d    = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_REQ;
            pc_q       <= RESET_PC_VAL;
            pend_pc_q  <= '0;
            squash_q   <= 1'b0;
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_pc_q  <= pend_pc_d;
            squash_q   <= squash_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] redir_cnt_q;

    // wrapping counters of delivered instructions and taken redirects
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            if (fetch_fire) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (taken) begin
                redir_cnt_q <= redir_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_redir_cnt = redir_cnt_q;
`else
    logic unused_fetch_fire;
    assign unused_fetch_fire = fetch_fire;
    assign perf_fetch_cnt    = '0;
    assign perf_redir_cnt    = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redir_ex_valid;
    logic [31:0] redir_ex_target;
    logic        redir_id_valid;
    logic [31:0] redir_id_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        flush_out;
    logic [31:0] pc_out;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_redir_cnt;

    int          checks   = 0;
    int          failures = 0;
    int          lat      = 1;
    logic [31:0] exp_q[$];

    fetch_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redir_ex_valid  (redir_ex_valid),
        .redir_ex_target (redir_ex_target),
        .redir_id_valid  (redir_id_valid),
        .redir_id_target (redir_id_target),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .flush_out       (flush_out),
        .pc_out          (pc_out),
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_redir_cnt  (perf_redir_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // IMEM model: accepts on valid & ready, answers after lat cycles
    initial begin : imem_model
        logic        acc;
        logic        pend;
        int          cnt;
        logic [31:0] a;
        pend = 1'b0;
        cnt  = 0;
        a    = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            #2;
            acc = rst_n & imem_req_valid & imem_req_ready;
            if (acc) begin
                pend = 1'b1;
                cnt  = lat;
                a    = imem_addr;
            end
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else if (pend) begin
                if (cnt <= 1) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(a);
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // wait for a delivered instruction and compare it against the scoreboard head
    task automatic get_one(input string tag);
        logic [31:0] e;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if_valid) break;
        end
        if (!if_valid) begin
            chk({tag, "_timeout"}, {31'd0, if_valid}, 32'd1);
        end else if (exp_q.size() == 0) begin
            chk({tag, "_unexpected"}, if_pc, 32'hDEAD_BEEF);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_pc"}, if_pc, e);
            chk({tag, "_instr"}, if_instr, mem_word(e));
            if (if_ready) @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] hold_pc;
        logic [31:0] hold_instr;
        rst_n           = 1'b0;
        redir_ex_valid  = 1'b0;
        redir_ex_target = '0;
        redir_id_valid  = 1'b0;
        redir_id_target = '0;
        imem_req_ready  = 1'b0;
        if_ready        = 1'b0;

        // T1 reset
        repeat (10) @(negedge clk);
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_perf_fetch", perf_fetch_cnt, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_pc", pc_out, 32'h4000_0000);
        chk("rel_addr", imem_addr, 32'h4000_0000);
        chk("rel_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("rel_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rel_flush", {31'd0, flush_out}, 32'd0);

        // T2 sequential fetch
        imem_req_ready = 1'b1;
        if_ready       = 1'b1;
        exp_q.push_back(32'h4000_0000);
        exp_q.push_back(32'h4000_0004);
        exp_q.push_back(32'h4000_0008);
        get_one("seq0");
        get_one("seq1");
        get_one("seq2");

        // T3 decode stall
        if_ready = 1'b0;
        exp_q.push_back(32'h4000_000C);
        get_one("stall");
        hold_pc    = if_pc;
        hold_instr = if_instr;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, if_valid}, 32'd1);
            chk("stall_pc", if_pc, hold_pc);
            chk("stall_instr", if_instr, hold_instr);
            chk("stall_req", {31'd0, imem_req_valid}, 32'd0);
            chk("stall_pc_out", pc_out, 32'h4000_0010);
        end
        if_ready = 1'b1;
        @(negedge clk);
        chk("stall_release", {31'd0, if_valid}, 32'd0);

        // T4 redirect while a request is outstanding
        lat = 3;
        for (int i = 0; i < 10; i++) begin
            if (imem_req_valid) break;
            @(negedge clk);
        end
        chk("t4_req_seen", {31'd0, imem_req_valid}, 32'd1);
        @(negedge clk);
        redir_ex_valid  = 1'b1;
        redir_ex_target = 32'h2000_0000;
        #1;
        chk("t4_flush_on", {31'd0, flush_out}, 32'd1);
        chk("t4_req_off", {31'd0, imem_req_valid}, 32'd0);
        @(negedge clk);
        redir_ex_valid = 1'b0;
        #1;
        chk("t4_flush_off", {31'd0, flush_out}, 32'd0);
        chk("t4_pc", pc_out, 32'h2000_0000);
        lat = 1;
        exp_q.push_back(32'h2000_0000);
        get_one("t4_refetch");

        // T5 simultaneous redirects, then unaligned ID target
        redir_ex_valid  = 1'b1;
        redir_ex_target = 32'h3000_0000;
        redir_id_valid  = 1'b1;
        redir_id_target = 32'h1000_0000;
        @(negedge clk);
        chk("t5_ex_wins", pc_out, 32'h3000_0000);
        redir_ex_valid  = 1'b0;
        redir_id_target = 32'h1000_0003;
        @(negedge clk);
        chk("t5_id_align", pc_out, 32'h1000_0000);
        redir_id_valid = 1'b0;
        exp_q.push_back(32'h1000_0000);
        get_one("t5_fetch");

        // PC wrap at the top of the address space
        redir_ex_valid  = 1'b1;
        redir_ex_target = 32'hFFFF_FFFC;
        @(negedge clk);
        redir_ex_valid = 1'b0;
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        get_one("wrap0");
        get_one("wrap1");

        // redirect in HOLD drops the instruction even with if_ready high
        if_ready = 1'b0;
        exp_q.push_back(32'h0000_0004);
        get_one("hold_pre");
        redir_id_valid  = 1'b1;
        redir_id_target = 32'h5000_0000;
        if_ready        = 1'b1;
        @(negedge clk);
        redir_id_valid = 1'b0;
        chk("hold_drop_valid", {31'd0, if_valid}, 32'd0);
        chk("hold_drop_pc", pc_out, 32'h5000_0000);
        exp_q.push_back(32'h5000_0000);
        get_one("hold_refetch");

        // T6 asynchronous reset in HOLD
        if_ready = 1'b0;
        exp_q.push_back(32'h5000_0004);
        get_one("t6_pre");
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_if_valid", {31'd0, if_valid}, 32'd0);
        chk("t6_pc", pc_out, 32'h4000_0000);
        chk("t6_req", {31'd0, imem_req_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        if_ready = 1'b1;
        exp_q.push_back(32'h4000_0000);
        exp_q.push_back(32'h4000_0004);
        exp_q.push_back(32'h4000_0008);
        get_one("t6_f0");
        get_one("t6_f1");
        get_one("t6_f2");
        redir_ex_valid  = 1'b1;
        redir_ex_target = 32'h4000_0100;
        @(negedge clk);
        redir_ex_valid = 1'b0;
        #1;
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch", perf_fetch_cnt, 32'd3);
        chk("perf_redir", perf_redir_cnt, 32'd1);
`else
        chk("perf_fetch_off", perf_fetch_cnt, 32'd0);
        chk("perf_redir_off", perf_redir_cnt, 32'd0);
`endif
        chk("t6_final_pc", pc_out, 32'h4000_0100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
